// File: rtl/wav_header_parser.sv
// wav_header_parser
//   Streaming RIFF/WAVE header parser. Every byte of the file is consumed and
//   the RIFF/WAVE container is validated. The `fmt ` fields are extracted and
//   unknown chunks are skipped. Only the `data` chunk payload is forwarded,
//   one cycle after it arrives. There is no backpressure.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_en, in_byte    input byte strobe and byte
//   out_en, out_byte  payload byte strobe and byte (1-cycle latency)
//   hdr_valid         sticky: format valid and data chunk started
//   hdr_error         sticky: malformed container, parsing stopped
//   data_done         sticky: all data_size payload bytes forwarded
//   num_channels, sample_rate, bits_per_sample, data_size  header fields
module wav_header_parser #(
    parameter bit REQUIRE_PCM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [7:0]  in_byte,
    output logic        out_en,
    output logic [7:0]  out_byte,
    output logic        hdr_valid,
    output logic        hdr_error,
    output logic        data_done,
    output logic [15:0] num_channels,
    output logic [31:0] sample_rate,
    output logic [15:0] bits_per_sample,
    output logic [31:0] data_size
);
    // Four-character codes as assembled little-endian in the shift register
    localparam logic [31:0] ID_RIFF = 32'h4646_4952;
    localparam logic [31:0] ID_WAVE = 32'h4556_4157;
    localparam logic [31:0] ID_FMT  = 32'h2074_6D66;
    localparam logic [31:0] ID_DATA = 32'h6174_6164;

    typedef enum logic [3:0] {
        S_RIFF_ID, S_RIFF_SIZE, S_WAVE_ID, S_CHUNK_ID, S_CHUNK_SIZE,
        S_FMT_BODY, S_SKIP_BODY, S_DATA, S_DONE, S_ERROR
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_sr, r_byte_cnt, r_chunk_id, r_chunk_len;
    logic [15:0] r_audio_format;
    logic        r_fmt_seen;
    logic        r_out_en, r_hdr_valid, r_hdr_error, r_data_done;
    logic [7:0]  r_out_byte;
    logic [15:0] r_num_channels, r_bits_per_sample;
    logic [31:0] r_sample_rate, r_data_size;

    logic [31:0] w_sr_next;
    logic        w_word_done, w_fmt_end, w_skip_end, w_data_end, w_fmt_ok;
    logic [15:0] w_bits;

    assign w_sr_next   = {in_byte, r_sr[31:8]};
    assign w_word_done = (r_byte_cnt == 32'd3);
    assign w_fmt_end   = ((r_byte_cnt + 32'd1) == r_chunk_len);
    assign w_data_end  = ((r_byte_cnt + 32'd1) == r_data_size);
    // Odd-length chunks carry one pad byte; 33 bits keeps 0xFFFFFFFF+pad exact
    assign w_skip_end  = (({1'b0, r_byte_cnt} + 33'd1) ==
                          ({1'b0, r_chunk_len} + {32'd0, r_chunk_len[0]}));
    // bits_per_sample may complete on the very byte that ends the fmt body
    assign w_bits      = (r_byte_cnt == 32'd15) ? w_sr_next[31:16] : r_bits_per_sample;
    assign w_fmt_ok    = (!REQUIRE_PCM || (r_audio_format == 16'd1)) &&
                         ((w_bits == 16'd8) || (w_bits == 16'd16) ||
                          (w_bits == 16'd24) || (w_bits == 16'd32)) &&
                         (r_num_channels != 16'd0);

    always_comb begin
        w_state_next = r_state;
        if (in_en) begin
            case (r_state)
                S_RIFF_ID:   if (w_word_done) w_state_next = (w_sr_next == ID_RIFF) ? S_RIFF_SIZE : S_ERROR;
                S_RIFF_SIZE: if (w_word_done) w_state_next = S_WAVE_ID;
                S_WAVE_ID:   if (w_word_done) w_state_next = (w_sr_next == ID_WAVE) ? S_CHUNK_ID : S_ERROR;
                S_CHUNK_ID:  if (w_word_done) w_state_next = S_CHUNK_SIZE;
                S_CHUNK_SIZE: begin
                    if (w_word_done) begin
                        if (r_chunk_id == ID_FMT)
                            w_state_next = (w_sr_next < 32'd16) ? S_ERROR : S_FMT_BODY;
                        else if (r_chunk_id == ID_DATA)
                            w_state_next = !r_fmt_seen ? S_ERROR :
                                           (w_sr_next == 32'd0) ? S_DONE : S_DATA;
                        else
                            w_state_next = (w_sr_next == 32'd0) ? S_CHUNK_ID : S_SKIP_BODY;
                    end
                end
                S_FMT_BODY:  if (w_fmt_end) w_state_next = w_fmt_ok ? S_CHUNK_ID : S_ERROR;
                S_SKIP_BODY: if (w_skip_end) w_state_next = S_CHUNK_ID;
                S_DATA:      if (w_data_end) w_state_next = S_DONE;
                default:     w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_RIFF_ID;
            r_sr              <= '0;
            r_byte_cnt        <= '0;
            r_chunk_id        <= '0;
            r_chunk_len       <= '0;
            r_audio_format    <= '0;
            r_fmt_seen        <= 1'b0;
            r_out_en          <= 1'b0;
            r_out_byte        <= '0;
            r_hdr_valid       <= 1'b0;
            r_hdr_error       <= 1'b0;
            r_data_done       <= 1'b0;
            r_num_channels    <= '0;
            r_sample_rate     <= '0;
            r_bits_per_sample <= '0;
            r_data_size       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_en    <= 1'b0;
            r_hdr_error <= (w_state_next == S_ERROR);
            if (in_en) begin
                r_sr       <= w_sr_next;
                r_byte_cnt <= (w_state_next != r_state) ? 32'd0 : r_byte_cnt + 32'd1;
                case (r_state)
                    S_CHUNK_ID: if (w_word_done) r_chunk_id <= w_sr_next;
                    S_CHUNK_SIZE: begin
                        if (w_word_done) begin
                            r_chunk_len <= w_sr_next;
                            if ((r_chunk_id == ID_DATA) && r_fmt_seen) begin
                                r_data_size <= w_sr_next;
                                r_hdr_valid <= 1'b1;
                                if (w_sr_next == 32'd0) r_data_done <= 1'b1;
                            end
                        end
                    end
                    S_FMT_BODY: begin
                        case (r_byte_cnt)
                            32'd1:   r_audio_format    <= w_sr_next[31:16];
                            32'd3:   r_num_channels    <= w_sr_next[31:16];
                            32'd7:   r_sample_rate     <= w_sr_next;
                            32'd15:  r_bits_per_sample <= w_sr_next[31:16];
                            default: ;
                        endcase
                        if (w_fmt_end && w_fmt_ok) r_fmt_seen <= 1'b1;
                    end
                    S_DATA: begin
                        r_out_en   <= 1'b1;
                        r_out_byte <= in_byte;
                        if (w_data_end) r_data_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_en          = r_out_en;
    assign out_byte        = r_out_byte;
    assign hdr_valid       = r_hdr_valid;
    assign hdr_error       = r_hdr_error;
    assign data_done       = r_data_done;
    assign num_channels    = r_num_channels;
    assign sample_rate     = r_sample_rate;
    assign bits_per_sample = r_bits_per_sample;
    assign data_size       = r_data_size;
endmodule

// File: tb/tb_wav_header_parser.sv
// Testbench for wav_header_parser: directed WAV files with hand-computed
// expectations. A second instance with REQUIRE_PCM=0 shares the input stream.
module tb_wav_header_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_en = 1'b0;
    logic [7:0]  in_byte = 8'h00;

    logic        out_en, hdr_valid, hdr_error, data_done;
    logic [7:0]  out_byte;
    logic [15:0] num_channels, bits_per_sample;
    logic [31:0] sample_rate, data_size;

    logic        np_out_en, np_hdr_valid, np_hdr_error, np_data_done;
    logic [7:0]  np_out_byte;
    logic [15:0] np_num_channels, np_bits_per_sample;
    logic [31:0] np_sample_rate, np_data_size;

    wav_header_parser #(.REQUIRE_PCM(1'b1)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_byte(in_byte),
        .out_en(out_en), .out_byte(out_byte),
        .hdr_valid(hdr_valid), .hdr_error(hdr_error), .data_done(data_done),
        .num_channels(num_channels), .sample_rate(sample_rate),
        .bits_per_sample(bits_per_sample), .data_size(data_size)
    );

    wav_header_parser #(.REQUIRE_PCM(1'b0)) dut_np (
        .clk(clk), .rst(rst), .in_en(in_en), .in_byte(in_byte),
        .out_en(np_out_en), .out_byte(np_out_byte),
        .hdr_valid(np_hdr_valid), .hdr_error(np_hdr_error), .data_done(np_data_done),
        .num_channels(np_num_channels), .sample_rate(np_sample_rate),
        .bits_per_sample(np_bits_per_sample), .data_size(np_data_size)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q_in[$];
    logic [7:0] q_out[$];

    task automatic p8(input logic [7:0] b);
        q_in.push_back(b);
    endtask
    task automatic p16(input logic [15:0] v);
        p8(v[7:0]); p8(v[15:8]);
    endtask
    task automatic p32(input logic [31:0] v);
        p16(v[15:0]); p16(v[31:16]);
    endtask
    task automatic pstr(input logic [31:0] s);
        p8(s[31:24]); p8(s[23:16]); p8(s[15:8]); p8(s[7:0]);
    endtask

    // Builds a file: optional bad magic, optional missing fmt, optional LIST
    // chunk (size 3 + pad), payload bytes 0..dsize-1, then 4 trailing bytes.
    task automatic build(input logic [15:0] af, input bit no_fmt, input bit riffx,
                         input bit list, input logic [31:0] dsize);
        q_in.delete();
        if (riffx) pstr("RIFX"); else pstr("RIFF");
        p32(32'd36);
        pstr("WAVE");
        if (!no_fmt) begin
            pstr("fmt "); p32(32'd16);
            p16(af); p16(16'd2); p32(32'd44100); p32(32'd176400); p16(16'd4); p16(16'd16);
        end
        if (list) begin
            pstr("LIST"); p32(32'd3);
            p8(8'h55); p8(8'h56); p8(8'h57); p8(8'h58);
        end
        pstr("data"); p32(dsize);
        for (int i = 0; i < int'(dsize); i++) p8(i[7:0]);
        for (int i = 0; i < 4; i++) p8(8'hAA);
    endtask

    // Payload monitor: each out_en must follow an accepted input byte
    logic       tb_prev_en = 1'b0;
    logic [7:0] tb_prev_byte = 8'h00;
    always @(posedge clk) begin
        tb_prev_en   <= in_en;
        tb_prev_byte <= in_byte;
    end
    always @(negedge clk) begin
        if (out_en) begin
            chk("out_latency", {31'd0, tb_prev_en}, 32'd1);
            chk("out_passthru", {24'd0, out_byte}, {24'd0, tb_prev_byte});
            q_out.push_back(out_byte);
        end
    end

    int hv_idx, dd_idx, er_idx, np_hv_idx;
    logic dd_out;

    // Streams up to max_bytes of q_in with one byte every gap cycles and
    // records the byte index at which each sticky flag first appeared.
    task automatic run_file(input int gap, input int max_bytes);
        q_out.delete();
        hv_idx = -1; dd_idx = -1; er_idx = -1; np_hv_idx = -1; dd_out = 1'b0;
        for (int i = 0; i < q_in.size() && i < max_bytes; i++) begin
            in_en = 1'b1; in_byte = q_in[i];
            @(posedge clk); #1;
            in_en = 1'b0;
            if (hdr_valid && hv_idx < 0) hv_idx = i;
            if (hdr_error && er_idx < 0) er_idx = i;
            if (np_hdr_valid && np_hv_idx < 0) np_hv_idx = i;
            if (data_done && dd_idx < 0) begin dd_idx = i; dd_out = out_en; end
            chk("valid_error_excl", {31'd0, hdr_valid & hdr_error}, 32'd0);
            for (int g = 1; g < gap; g++) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_payload(input string tag, input int n);
        chk({tag, "_count"}, q_out.size(), n);
        for (int i = 0; i < q_out.size() && i < n; i++)
            chk({tag, "_byte"}, {24'd0, q_out[i]}, i);
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_rate"}, sample_rate, 32'h0000AC44);
        chk({tag, "_nch"}, {16'd0, num_channels}, 32'd2);
        chk({tag, "_bits"}, {16'd0, bits_per_sample}, 32'd16);
        chk({tag, "_dsize"}, data_size, 32'd8);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", {31'd0, hdr_valid}, 32'd0);
        chk("rst_error", {31'd0, hdr_error}, 32'd0);
        chk("rst_done", {31'd0, data_done}, 32'd0);
        chk("rst_out_en", {31'd0, out_en}, 32'd0);
        chk("rst_rate", sample_rate, 32'd0);
        chk("rst_dsize", data_size, 32'd0);

        // Canonical file, back-to-back bytes
        build(16'd1, 1'b0, 1'b0, 1'b0, 32'd8);
        run_file(1, 1000);
        chk("canon_hv_idx", hv_idx, 43);
        chk("canon_done_idx", dd_idx, 51);
        chk("canon_done_with_out", {31'd0, dd_out}, 32'd1);
        chk("canon_err_idx", er_idx, -1);
        chk_payload("canon", 8);
        chk_fields("canon");

        // LIST chunk with pad byte, sparse input
        do_reset();
        build(16'd1, 1'b0, 1'b0, 1'b1, 32'd8);
        run_file(3, 1000);
        chk("list_hv_idx", hv_idx, 55);
        chk("list_done_idx", dd_idx, 63);
        chk("list_done_with_out", {31'd0, dd_out}, 32'd1);
        chk_payload("list", 8);
        chk_fields("list");

        // Bad magic
        do_reset();
        build(16'd1, 1'b0, 1'b1, 1'b0, 32'd8);
        run_file(1, 1000);
        chk("rifx_err_idx", er_idx, 3);
        chk("rifx_hv_idx", hv_idx, -1);
        chk("rifx_nout", q_out.size(), 0);

        // Float format: rejected with REQUIRE_PCM=1, accepted otherwise
        do_reset();
        build(16'd3, 1'b0, 1'b0, 1'b0, 32'd8);
        run_file(1, 1000);
        chk("float_err_idx", er_idx, 35);
        chk("float_hv_idx", hv_idx, -1);
        chk("float_np_hv_idx", np_hv_idx, 43);
        chk("float_nout", q_out.size(), 0);

        // data chunk before fmt
        do_reset();
        build(16'd1, 1'b1, 1'b0, 1'b0, 32'd8);
        run_file(1, 1000);
        chk("nofmt_err_idx", er_idx, 19);
        chk("nofmt_hv_idx", hv_idx, -1);

        // Empty data chunk
        do_reset();
        build(16'd1, 1'b0, 1'b0, 1'b0, 32'd0);
        run_file(1, 1000);
        chk("empty_hv_idx", hv_idx, 43);
        chk("empty_done_idx", dd_idx, 43);
        chk("empty_nout", q_out.size(), 0);
        chk("empty_err", {31'd0, hdr_error}, 32'd0);

        // Reset after 3 payload bytes, then re-stream the whole file
        do_reset();
        build(16'd1, 1'b0, 1'b0, 1'b0, 32'd8);
        run_file(1, 47);
        chk_payload("part", 3);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, hdr_valid}, 32'd0);
        chk("async_rst_dsize", data_size, 32'd0);
        chk("async_rst_rate", sample_rate, 32'd0);
        chk("async_rst_nch", {16'd0, num_channels}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_file(1, 1000);
        chk("restart_hv_idx", hv_idx, 43);
        chk("restart_done_idx", dd_idx, 51);
        chk_payload("restart", 8);
        chk_fields("restart");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
